// File: rtl/irq_decode_ctrl_pkg.sv
// Shared opcode, cause-code and interrupt FSM definitions for the decode stage.
// Every decode-stage file imports this package.
package irq_decode_ctrl_pkg;

    localparam int OP_W    = 6;
    localparam int CAUSE_B = 3;

    localparam logic [OP_W-1:0] OP_AR               = 6'h00;
    localparam logic [OP_W-1:0] OP_J                = 6'h02;
    localparam logic [OP_W-1:0] OP_BEQ              = 6'h04;
    localparam logic [OP_W-1:0] OP_BNE              = 6'h05;
    localparam logic [OP_W-1:0] OP_ADDI             = 6'h08;
    localparam logic [OP_W-1:0] OP_ADDIU            = 6'h09;
    localparam logic [OP_W-1:0] OP_SLTI             = 6'h0A;
    localparam logic [OP_W-1:0] OP_SLTIU            = 6'h0B;
    localparam logic [OP_W-1:0] OP_ANDI             = 6'h0C;
    localparam logic [OP_W-1:0] OP_ORI              = 6'h0D;
    localparam logic [OP_W-1:0] OP_ANDIU            = 6'h1C;
    localparam logic [OP_W-1:0] OP_ORIU             = 6'h1D;
    localparam logic [OP_W-1:0] OP_LW               = 6'h23;
    localparam logic [OP_W-1:0] OP_SW               = 6'h2B;
    localparam logic [OP_W-1:0] OP_SYSCALL          = 6'h30;
    localparam logic [OP_W-1:0] OP_INTERRUPTS_J     = 6'h38;
    localparam logic [OP_W-1:0] OP_INTERRUPTS_ADDR  = 6'h39;
    localparam logic [OP_W-1:0] OP_EMPTY            = 6'h3E;

    localparam logic [CAUSE_B-1:0] CAUSE_NONE    = 3'b100;
    localparam logic [CAUSE_B-1:0] CAUSE_ILLEGAL = 3'b001;
    localparam logic [CAUSE_B-1:0] CAUSE_SYSCALL = 3'b011;
    localparam logic [CAUSE_B-1:0] CAUSE_EXT_IRQ = 3'b010;

    typedef enum logic [1:0] {
        ST_RUN      = 2'd0,
        ST_INJ_J    = 2'd1,
        ST_INJ_ADDR = 2'd2,
        ST_HANDLER  = 2'd3
    } irq_state_t;

    function automatic logic isKnownOpcode(input logic [OP_W-1:0] op);
        case (op)
            OP_AR, OP_J, OP_BEQ, OP_BNE, OP_ADDI, OP_ADDIU, OP_SLTI, OP_SLTIU,
            OP_ANDI, OP_ORI, OP_ANDIU, OP_ORIU, OP_LW, OP_SW, OP_SYSCALL,
            OP_INTERRUPTS_J, OP_INTERRUPTS_ADDR, OP_EMPTY: return 1'b1;
            default: return 1'b0;
        endcase
    endfunction

    function automatic logic writesRegFile(input logic [OP_W-1:0] op);
        case (op)
            OP_AR, OP_ADDIU, OP_ADDI, OP_ANDIU, OP_ANDI, OP_ORIU, OP_ORI,
            OP_SLTIU, OP_SLTI, OP_LW: return 1'b1;
            default: return 1'b0;
        endcase
    endfunction

    // Branches and memory ops route the register file reads differently.
    function automatic logic isBranchOrMem(input logic [OP_W-1:0] op);
        case (op)
            OP_BEQ, OP_BNE, OP_LW, OP_SW: return 1'b1;
            default: return 1'b0;
        endcase
    endfunction

endpackage

// File: rtl/irq_decode_ctrl_prio_enc.sv
// Fixed-priority encoder over the eligible interrupt vector.
// The lowest set index wins.
module irq_prio_enc #(
    parameter int N_IRQ = 4,
    parameter int IDX_W = (N_IRQ > 1) ? $clog2(N_IRQ) : 1
) (
    input  logic [N_IRQ-1:0] i_vec,
    output logic             o_any,
    output logic [IDX_W-1:0] o_idx
);

    // Scan from the top down so the lowest set bit is written last.
    always_comb begin
        o_any = |i_vec;
        o_idx = '0;
        for (int i = N_IRQ - 1; i >= 0; i--) begin
            if (i_vec[i]) begin
                o_idx = IDX_W'(i);
            end
        end
    end

endmodule

// File: rtl/irq_decode_ctrl.sv
// Decode stage (step2) with external interrupt injection.
// A taken interrupt is inserted as a two-op sequence (J marker, then ADDR marker) ahead of handler entry.
module irq_decode_ctrl
    import irq_decode_ctrl_pkg::*;
#(
    parameter int N_IRQ    = 4,
    parameter int OPCODE_W = 6,
    parameter int CAUSE_W  = 3
) (
    input  logic                                     clk,
    input  logic                                     reset_n,
    input  logic [OPCODE_W-1:0]                      opcode,
    input  logic                                     valid_in,
    input  logic [CAUSE_W-1:0]                       cause_in,
    input  logic                                     stall_from_step3,
    input  logic [N_IRQ-1:0]                         irq_req,
    input  logic [N_IRQ-1:0]                         irq_mask,
    input  logic                                     irq_done,
    output logic                                     rf_w,
    output logic                                     mux_rf_rn1_select,
    output logic                                     mux_rf_rn2_select,
    output logic                                     valid_out,
    output logic [CAUSE_W-1:0]                       cause_out,
    output logic                                     interrupts_j,
    output logic                                     interrupts_addr_add,
    output logic                                     stall_to_step1,
    output logic [((N_IRQ > 1) ? $clog2(N_IRQ) : 1)-1:0] irq_id,
    output logic                                     in_handler
);

    localparam int ID_W = (N_IRQ > 1) ? $clog2(N_IRQ) : 1;
    localparam logic [CAUSE_W-1:0] C_NONE    = CAUSE_W'(CAUSE_NONE);
    localparam logic [CAUSE_W-1:0] C_ILLEGAL = CAUSE_W'(CAUSE_ILLEGAL);
    localparam logic [CAUSE_W-1:0] C_SYSCALL = CAUSE_W'(CAUSE_SYSCALL);
    localparam logic [CAUSE_W-1:0] C_EXT_IRQ = CAUSE_W'(CAUSE_EXT_IRQ);

    irq_state_t r_state, w_nextState;

    logic [N_IRQ-1:0]   r_pending, r_irqPrev;
    logic [N_IRQ-1:0]   w_rise, w_eligible, w_clear;
    logic               w_any, w_take;
    logic [ID_W-1:0]    w_prioIdx;
    logic [ID_W-1:0]    r_irqId;
    logic               r_inHandler;

    logic               r_rfW, r_sel1, r_sel2, r_valid, r_j, r_addr;
    logic [CAUSE_W-1:0] r_cause;
    logic               w_rfW, w_sel, w_valid, w_j, w_addr, w_stall1;
    logic [CAUSE_W-1:0] w_cause;
    logic [OP_W-1:0]    w_op;

    assign w_op       = OP_W'(opcode);
    assign w_rise     = irq_req & ~r_irqPrev;
    assign w_eligible = r_pending & irq_mask;
    assign w_take     = (r_state == ST_RUN) && w_any && !stall_from_step3;

    irq_prio_enc #(.N_IRQ(N_IRQ), .IDX_W(ID_W)) u_prioEnc (
        .i_vec (w_eligible),
        .o_any (w_any),
        .o_idx (w_prioIdx)
    );

    always_comb begin
        w_clear = '0;
        if (w_take) begin
            w_clear[w_prioIdx] = 1'b1;
        end
    end

    always_comb begin
        w_nextState = r_state;
        case (r_state)
            ST_RUN:      if (w_take)            w_nextState = ST_INJ_J;
            ST_INJ_J:    if (!stall_from_step3) w_nextState = ST_INJ_ADDR;
            ST_INJ_ADDR: if (!stall_from_step3) w_nextState = ST_HANDLER;
            ST_HANDLER:  if (irq_done)          w_nextState = ST_RUN;
            default:                            w_nextState = ST_RUN;
        endcase
    end

    // Everything defaults to a bubble; the taking cycle itself is a bubble so step1 keeps its op.
    always_comb begin
        w_valid  = 1'b0;
        w_rfW    = 1'b0;
        w_sel    = 1'b1;
        w_cause  = C_NONE;
        w_j      = 1'b0;
        w_addr   = 1'b0;
        w_stall1 = stall_from_step3;
        if (!stall_from_step3) begin
            case (r_state)
                ST_INJ_J, ST_INJ_ADDR: begin
                    w_stall1 = 1'b1;
                    w_valid  = 1'b1;
                    w_cause  = C_EXT_IRQ;
                    w_j      = (r_state == ST_INJ_J);
                    w_addr   = (r_state == ST_INJ_ADDR);
                end
                ST_RUN, ST_HANDLER: begin
                    if ((r_state == ST_RUN) && w_any) begin
                        w_stall1 = 1'b1;
                    end else if (valid_in) begin
                        w_valid = 1'b1;
                        w_rfW   = writesRegFile(w_op);
                        w_sel   = !isBranchOrMem(w_op);
                        if (cause_in != C_NONE) begin
                            w_cause = cause_in;
                        end else if (w_op == OP_SYSCALL) begin
                            w_cause = C_SYSCALL;
                        end else if (!isKnownOpcode(w_op)) begin
                            w_cause = C_ILLEGAL;
                        end
                    end
                end
                default: w_stall1 = 1'b1;
            endcase
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state     <= ST_RUN;
            r_pending   <= '0;
            r_irqPrev   <= '0;
            r_irqId     <= '0;
            r_inHandler <= 1'b0;
        end else begin
            r_state     <= w_nextState;
            r_pending   <= (r_pending & ~w_clear) | w_rise;
            r_irqPrev   <= irq_req;
            r_irqId     <= w_take ? w_prioIdx : r_irqId;
            r_inHandler <= (w_nextState == ST_HANDLER);
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_valid <= 1'b0;
            r_rfW   <= 1'b0;
            r_sel1  <= 1'b1;
            r_sel2  <= 1'b1;
            r_cause <= C_NONE;
            r_j     <= 1'b0;
            r_addr  <= 1'b0;
        end else begin
            r_valid <= w_valid;
            r_rfW   <= w_rfW;
            r_sel1  <= w_sel;
            r_sel2  <= w_sel;
            r_cause <= w_cause;
            r_j     <= w_j;
            r_addr  <= w_addr;
        end
    end

    assign rf_w                = r_rfW;
    assign mux_rf_rn1_select   = r_sel1;
    assign mux_rf_rn2_select   = r_sel2;
    assign valid_out           = r_valid;
    assign cause_out           = r_cause;
    assign interrupts_j        = r_j;
    assign interrupts_addr_add = r_addr;
    assign stall_to_step1      = w_stall1;
    assign irq_id              = r_irqId;
    assign in_handler          = r_inHandler;

endmodule

// File: tb/tb_irq_decode_ctrl.sv
// Directed bench for irq_decode_ctrl: decode table, cause priority, interrupt injection, stalls and reset.
// Inputs change 1ns after the rising edge; outputs are sampled at that point.
module tb_irq_decode_ctrl;
    import irq_decode_ctrl_pkg::*;

    logic       clk = 1'b0;
    logic       reset_n;
    logic [5:0] opcode;
    logic       valid_in;
    logic [2:0] cause_in;
    logic       stall_from_step3;
    logic [3:0] irq_req;
    logic [3:0] irq_mask;
    logic       irq_done;
    logic       rf_w, sel1, sel2, valid_out, interrupts_j, interrupts_addr_add;
    logic       stall_to_step1, in_handler;
    logic [2:0] cause_out;
    logic [1:0] irq_id;

    int errorCount = 0;
    int checkCount = 0;

    irq_decode_ctrl #(.N_IRQ(4), .OPCODE_W(6), .CAUSE_W(3)) dut (
        .clk                 (clk),
        .reset_n             (reset_n),
        .opcode              (opcode),
        .valid_in            (valid_in),
        .cause_in            (cause_in),
        .stall_from_step3    (stall_from_step3),
        .irq_req             (irq_req),
        .irq_mask            (irq_mask),
        .irq_done            (irq_done),
        .rf_w                (rf_w),
        .mux_rf_rn1_select   (sel1),
        .mux_rf_rn2_select   (sel2),
        .valid_out           (valid_out),
        .cause_out           (cause_out),
        .interrupts_j        (interrupts_j),
        .interrupts_addr_add (interrupts_addr_add),
        .stall_to_step1      (stall_to_step1),
        .irq_id              (irq_id),
        .in_handler          (in_handler)
    );

    always #5 clk = ~clk;

    task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
        checkCount++;
        if (actual !== expected) begin
            errorCount++;
            $display("[TB] FAIL %s: got %0h expected %0h", tag, actual, expected);
        end
    endtask

    task automatic applyStimulus(input logic [5:0] op, input logic vin, input logic [2:0] cin);
        opcode   = op;
        valid_in = vin;
        cause_in = cin;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic pulseDone();
        irq_done = 1'b1;
        tick();
        irq_done = 1'b0;
    endtask

    task automatic checkResetValues(input string tag);
        checkOutput({tag, "_valid"}, valid_out, 0);
        checkOutput({tag, "_rfw"}, rf_w, 0);
        checkOutput({tag, "_sel1"}, sel1, 1);
        checkOutput({tag, "_sel2"}, sel2, 1);
        checkOutput({tag, "_cause"}, cause_out, 3'b100);
        checkOutput({tag, "_j"}, interrupts_j, 0);
        checkOutput({tag, "_addr"}, interrupts_addr_add, 0);
        checkOutput({tag, "_irqid"}, irq_id, 0);
        checkOutput({tag, "_inh"}, in_handler, 0);
    endtask

    initial begin
        #100000;
        $display("[TB] FAIL watchdog: got timeout expected finish");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        reset_n          = 1'b0;
        stall_from_step3 = 1'b0;
        irq_req          = 4'b0000;
        irq_mask         = 4'b0000;
        irq_done         = 1'b0;
        applyStimulus(OP_AR, 1'b0, 3'b100);
        repeat (2) tick();
        checkResetValues("rst");
        reset_n = 1'b1;

        applyStimulus(OP_LW, 1'b1, 3'b100);
        tick();
        checkOutput("lw_rfw", rf_w, 1);
        checkOutput("lw_sel1", sel1, 0);
        checkOutput("lw_sel2", sel2, 0);
        checkOutput("lw_cause", cause_out, 3'b100);
        checkOutput("lw_valid", valid_out, 1);

        applyStimulus(6'h3F, 1'b1, 3'b100);
        tick();
        checkOutput("illegal_cause", cause_out, 3'b001);
        checkOutput("illegal_rfw", rf_w, 0);
        applyStimulus(6'h3F, 1'b1, 3'b011);
        tick();
        checkOutput("prior_cause", cause_out, 3'b011);
        applyStimulus(OP_SYSCALL, 1'b1, 3'b100);
        tick();
        checkOutput("syscall_cause", cause_out, 3'b011);
        applyStimulus(OP_BEQ, 1'b1, 3'b100);
        tick();
        checkOutput("beq_rfw", rf_w, 0);
        checkOutput("beq_sel1", sel1, 0);
        applyStimulus(OP_ADDI, 1'b1, 3'b100);
        tick();
        checkOutput("addi_rfw", rf_w, 1);
        checkOutput("addi_sel2", sel2, 1);
        applyStimulus(OP_J, 1'b1, 3'b100);
        tick();
        checkOutput("j_cause", cause_out, 3'b100);
        checkOutput("j_rfw", rf_w, 0);
        applyStimulus(OP_AR, 1'b0, 3'b100);
        tick();
        checkOutput("novalid_valid", valid_out, 0);

        applyStimulus(OP_AR, 1'b1, 3'b100);
        stall_from_step3 = 1'b1;
        #1;
        checkOutput("stall_st1", stall_to_step1, 1);
        tick();
        checkOutput("stall_valid", valid_out, 0);
        checkOutput("stall_rfw", rf_w, 0);
        stall_from_step3 = 1'b0;
        #1;
        checkOutput("nostall_st1", stall_to_step1, 0);

        // Masked channel still latches its edge and is taken once unmasked.
        irq_req = 4'b0001;
        tick();
        tick();
        checkOutput("masked_st1", stall_to_step1, 0);
        checkOutput("masked_valid", valid_out, 1);
        checkOutput("masked_j", interrupts_j, 0);
        irq_mask = 4'b0001;
        #1;
        checkOutput("unmask_st1", stall_to_step1, 1);
        tick();
        checkOutput("unmask_id", irq_id, 0);
        checkOutput("unmask_bubble", valid_out, 0);
        tick();
        checkOutput("unmask_j", interrupts_j, 1);
        tick();
        checkOutput("unmask_addr", interrupts_addr_add, 1);
        checkOutput("unmask_inh", in_handler, 1);
        pulseDone();
        checkOutput("done0_inh", in_handler, 0);
        irq_req = 4'b0000;

        // Two channels pending together with a SYSCALL waiting in step1.
        irq_mask = 4'b1111;
        irq_req  = 4'b1010;
        applyStimulus(OP_AR, 1'b0, 3'b100);
        #1;
        checkOutput("edge_st1", stall_to_step1, 0);
        tick();
        applyStimulus(OP_SYSCALL, 1'b1, 3'b100);
        #1;
        checkOutput("take_st1", stall_to_step1, 1);
        tick();
        checkOutput("take_id", irq_id, 1);
        checkOutput("take_bubble", valid_out, 0);
        checkOutput("take_j0", interrupts_j, 0);
        tick();
        checkOutput("inj_j", interrupts_j, 1);
        checkOutput("inj_j_valid", valid_out, 1);
        checkOutput("inj_j_cause", cause_out, 3'b010);
        checkOutput("inj_j_rfw", rf_w, 0);
        tick();
        checkOutput("inj_addr", interrupts_addr_add, 1);
        checkOutput("inj_addr_j", interrupts_j, 0);
        checkOutput("inj_inh", in_handler, 1);
        tick();
        checkOutput("sys_after_cause", cause_out, 3'b011);
        checkOutput("sys_after_valid", valid_out, 1);
        checkOutput("sys_after_addr", interrupts_addr_add, 0);
        applyStimulus(OP_AR, 1'b0, 3'b100);

        // New edge while in the handler must wait for irq_done.
        irq_req = 4'b1011;
        for (int i = 0; i < 3; i++) begin
            tick();
            checkOutput("hdl_block_j", interrupts_j, 0);
            checkOutput("hdl_block_inh", in_handler, 1);
        end
        pulseDone();
        checkOutput("done1_inh", in_handler, 0);
        checkOutput("done1_st1", stall_to_step1, 1);
        tick();
        checkOutput("ch0_id", irq_id, 0);
        tick();
        checkOutput("ch0_j", interrupts_j, 1);
        tick();
        checkOutput("ch0_addr", interrupts_addr_add, 1);
        pulseDone();
        tick();
        checkOutput("ch3_id", irq_id, 3);

        // Stall held for three cycles while in INJ_J.
        stall_from_step3 = 1'b1;
        for (int i = 0; i < 3; i++) begin
            tick();
            checkOutput("injstall_valid", valid_out, 0);
            checkOutput("injstall_j", interrupts_j, 0);
        end
        stall_from_step3 = 1'b0;
        tick();
        checkOutput("ch3_j", interrupts_j, 1);
        tick();
        checkOutput("ch3_j_once", interrupts_j, 0);
        checkOutput("ch3_addr", interrupts_addr_add, 1);
        tick();
        checkOutput("ch3_addr_once", interrupts_addr_add, 0);
        pulseDone();

        // Reset arriving in INJ_ADDR abandons the service.
        irq_req = 4'b1111;
        tick();
        tick();
        checkOutput("ch2_id", irq_id, 2);
        tick();
        checkOutput("ch2_j", interrupts_j, 1);
        reset_n = 1'b0;
        #1;
        checkResetValues("midrst");
        irq_req = 4'b0000;
        tick();
        reset_n = 1'b1;
        for (int i = 0; i < 4; i++) begin
            tick();
            checkOutput("postrst_j", interrupts_j, 0);
            checkOutput("postrst_addr", interrupts_addr_add, 0);
            checkOutput("postrst_st1", stall_to_step1, 0);
        end

        $display("Result: errors=%0d of %0d checks", errorCount, checkCount);
        $finish;
    end

endmodule
